// File: rtl/cv32e40s_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40s_pkg
// Shared types and RV32I encoding helpers for the Zcmp micro-op sequencer.
//   seq_state_e : sequencer FSM states
//   zcmp_op_e   : Zcmp operation being expanded
//   OPCODE_*    : RV32I major opcodes used by the generated micro-ops
//   enc_i/enc_s : I-type / S-type instruction word builders
//   sreg        : r1s'/r2s' field -> architectural register
//   rlist_reg   : step index within a push/pop register list -> register
// ---------------------------------------------------------------------------
package cv32e40s_pkg;

    typedef enum logic {
        IDLE,
        SEQ
    } seq_state_e;

    typedef enum logic [2:0] {
        PUSH,
        POP,
        POPRETZ,
        POPRET,
        MVSA01,
        MVA01S
    } zcmp_op_e;

    localparam logic [6:0] OPCODE_STORE = 7'b0100011;
    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

    localparam logic [2:0] FUNCT3_SW   = 3'b010;
    localparam logic [2:0] FUNCT3_LW   = 3'b010;
    localparam logic [2:0] FUNCT3_ADDI = 3'b000;
    localparam logic [2:0] FUNCT3_JALR = 3'b000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_SP   = 5'd2;
    localparam logic [4:0] REG_A0   = 5'd10;
    localparam logic [4:0] REG_A1   = 5'd11;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] funct3, input logic [4:0] rd,
                                          input logic [6:0] opcode);
        return {imm, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] funct3,
                                          input logic [6:0] opcode);
        return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
    endfunction

    // s0,s1 are x8,x9; s2..s7 continue at x18.
    function automatic logic [4:0] sreg(input logic [2:0] r);
        return (r < 3'd2) ? {4'b0100, r[0]} : ({2'b00, r} + 5'd16);
    endfunction

    // Register list order is ra, s0, s1, s2..s11 (x18..x27).
    function automatic logic [4:0] rlist_reg(input logic [4:0] k);
        logic [4:0] r;
        case (k)
            5'd0:    r = REG_RA;
            5'd1:    r = 5'd8;
            5'd2:    r = 5'd9;
            default: r = k + 5'd15;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cv32e40s_zcmp_uop_gen.sv
// ---------------------------------------------------------------------------
// cv32e40s_zcmp_uop_gen
// Combinational micro-op generator: for a decoded Zcmp op and a step index,
// produces the RV32I word for that step and flags the final step.
//   op     in   zcmp_op_e  operation being expanded
//   rlist  in   4          register list field (>= 4 for push/pop)
//   spimm  in   2          extra stack adjustment in 16-byte units
//   r1s    in   3          r1s' field (mv ops)
//   r2s    in   3          r2s' field (mv ops)
//   step   in   5          index of the micro-op to produce
//   uop    out  32         micro-op instruction word
//   last   out  1          step is the final micro-op of the sequence
// ---------------------------------------------------------------------------
module cv32e40s_zcmp_uop_gen
    import cv32e40s_pkg::*;
(
    input  zcmp_op_e    op,
    input  logic [3:0]  rlist,
    input  logic [1:0]  spimm,
    input  logic [2:0]  r1s,
    input  logic [2:0]  r2s,
    input  logic [4:0]  step,
    output logic [31:0] uop,
    output logic        last
);

    logic [3:0]  nregs;
    logic [4:0]  nregs5;
    logic [4:0]  nregs_rnd;
    logic [6:0]  adj;
    logic [11:0] adj_pos;
    logic [11:0] adj_neg;
    logic [4:0]  slot;
    logic [11:0] slot_off;
    logic [4:0]  tail;
    logic [4:0]  len;
    logic [4:0]  reg_k;

    // rlist=15 skips s10 alone: {ra, s0-s11} is 13 registers.
    assign nregs     = (rlist == 4'd15) ? 4'd13 : (rlist - 4'd3);
    assign nregs5    = {1'b0, nregs};
    // Register area rounded up to 16 bytes, plus spimm*16; max 64+48=112.
    assign nregs_rnd = nregs5 + 5'd3;
    assign adj       = {nregs_rnd[4:2], 4'b0000} + {1'b0, spimm, 4'b0000};
    assign adj_pos   = {5'b00000, adj};
    assign adj_neg   = 12'd0 - adj_pos;
    // Register k lives at offset -4(k+1) from the pre-push sp.
    assign slot      = step + 5'd1;
    assign slot_off  = {5'b00000, slot, 2'b00};
    assign tail      = step - nregs5;
    assign reg_k     = rlist_reg(step);

    always_comb begin
        len = 5'd2;
        case (op)
            PUSH, POP: len = nregs5 + 5'd1;
            POPRET:    len = nregs5 + 5'd2;
            POPRETZ:   len = nregs5 + 5'd3;
            default:   len = 5'd2;
        endcase
    end

    assign last = (step == (len - 5'd1));

    always_comb begin
        uop = 32'h0000_0000;
        case (op)
            PUSH: begin
                if (step < nregs5) uop = enc_s(12'd0 - slot_off, reg_k, REG_SP, FUNCT3_SW, OPCODE_STORE);
                else               uop = enc_i(adj_neg, REG_SP, FUNCT3_ADDI, REG_SP, OPCODE_OPIMM);
            end
            POP, POPRET, POPRETZ: begin
                if (step < nregs5) begin
                    uop = enc_i(adj_pos - slot_off, REG_SP, FUNCT3_LW, reg_k, OPCODE_LOAD);
                end else if (op == POPRETZ && tail == 5'd0) begin
                    uop = enc_i(12'd0, REG_ZERO, FUNCT3_ADDI, REG_A0, OPCODE_OPIMM);
                end else if ((op == POP) || (op == POPRET && tail == 5'd0) ||
                             (op == POPRETZ && tail == 5'd1)) begin
                    uop = enc_i(adj_pos, REG_SP, FUNCT3_ADDI, REG_SP, OPCODE_OPIMM);
                end else begin
                    uop = enc_i(12'd0, REG_RA, FUNCT3_JALR, REG_ZERO, OPCODE_JALR);
                end
            end
            MVSA01: begin
                if (step == 5'd0) uop = enc_i(12'd0, REG_A0, FUNCT3_ADDI, sreg(r1s), OPCODE_OPIMM);
                else              uop = enc_i(12'd0, REG_A1, FUNCT3_ADDI, sreg(r2s), OPCODE_OPIMM);
            end
            MVA01S: begin
                if (step == 5'd0) uop = enc_i(12'd0, sreg(r1s), FUNCT3_ADDI, REG_A0, OPCODE_OPIMM);
                else              uop = enc_i(12'd0, sreg(r2s), FUNCT3_ADDI, REG_A1, OPCODE_OPIMM);
            end
            default: uop = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/cv32e40s_zcmp_sequencer.sv
// ---------------------------------------------------------------------------
// cv32e40s_zcmp_sequencer
// Sits between IF and the decoder. Zcmp push/pop/popret/popretz (and mv ops
// when CV32E40S_ZCMP_MV_EN is defined) are expanded into RV32I micro-ops, one
// per accepted cycle; every other instruction passes through combinationally.
//   clk, rst        clock, synchronous active-high reset
//   instr_i         instruction from IF (compressed in [15:0])
//   instr_valid_i   instr_i valid
//   instr_ready_o   instr_i consumed, IF may advance
//   instr_o         instruction or micro-op to the decoder
//   instr_valid_o   instr_o valid
//   id_ready_i      decoder accepts instr_o
//   kill_i          flush: abort any sequence
//   halt_i          stall: hold state, suppress valid/ready
//   seq_valid_o     instr_o is a sequenced micro-op
//   seq_first_o     first micro-op of a sequence
//   seq_last_o      last micro-op of a sequence
//   busy_o          sequence in progress (step != 0)
// Parameter SEQ_EN=0 gives a stateless passthrough.
// Macro CV32E40S_ZCMP_MV_EN enables sequencing of cm.mvsa01/cm.mva01s.
//
// Handshake: a micro-op transfers to the decoder in a cycle where
// instr_valid_o & id_ready_i; instr_o is held stable until that happens.
// IF keeps instr_i/instr_valid_i stable until instr_ready_o, which for a
// sequenced instruction only rises with the last micro-op.
// ---------------------------------------------------------------------------
module cv32e40s_zcmp_sequencer
    import cv32e40s_pkg::*;
#(
    parameter bit SEQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        id_ready_i,
    input  logic        kill_i,
    input  logic        halt_i,
    output logic        seq_valid_o,
    output logic        seq_first_o,
    output logic        seq_last_o,
    output logic        busy_o
);

    generate
        if (SEQ_EN) begin : g_seq
            seq_state_e  state;
            logic [4:0]  step;
            logic [4:0]  cur_step;
            zcmp_op_e    dec_op;
            logic        dec_hit;
            logic        rlist_ok;
            logic [31:0] uop;
            logic        uop_last;
            logic        active;

            assign rlist_ok = (instr_i[7:4] >= 4'd4);

            always_comb begin
                dec_op  = PUSH;
                dec_hit = 1'b0;
                if (instr_i[1:0] == 2'b10 && instr_i[15:13] == 3'b101) begin
                    case (instr_i[12:8])
                        5'b11000: begin dec_op = PUSH;    dec_hit = rlist_ok; end
                        5'b11010: begin dec_op = POP;     dec_hit = rlist_ok; end
                        5'b11100: begin dec_op = POPRETZ; dec_hit = rlist_ok; end
                        5'b11110: begin dec_op = POPRET;  dec_hit = rlist_ok; end
                        default:  dec_hit = 1'b0;
                    endcase
`ifdef CV32E40S_ZCMP_MV_EN
                    if (instr_i[12:10] == 3'b011) begin
                        if (instr_i[6:5] == 2'b01) begin
                            dec_op  = MVSA01;
                            // Same destination twice is reserved; leave it to the decoder.
                            dec_hit = (instr_i[9:7] != instr_i[4:2]);
                        end else if (instr_i[6:5] == 2'b11) begin
                            dec_op  = MVA01S;
                            dec_hit = 1'b1;
                        end
                    end
`endif
                end
            end

            // IDLE always presents step 0, whatever the counter holds.
            assign cur_step = (state == IDLE) ? 5'd0 : step;

            cv32e40s_zcmp_uop_gen u_uop_gen (
                .op    (dec_op),
                .rlist (instr_i[7:4]),
                .spimm (instr_i[3:2]),
                .r1s   (instr_i[9:7]),
                .r2s   (instr_i[4:2]),
                .step  (cur_step),
                .uop   (uop),
                .last  (uop_last)
            );

            assign active        = ~rst & ~kill_i & ~halt_i;
            assign instr_valid_o = instr_valid_i & active;
            assign instr_o       = rst ? 32'h0000_0000 : (dec_hit ? uop : instr_i);
            assign seq_valid_o   = dec_hit & instr_valid_o;
            assign seq_first_o   = seq_valid_o & (cur_step == 5'd0);
            assign seq_last_o    = seq_valid_o & uop_last;
            assign instr_ready_o = dec_hit ? (id_ready_i & instr_valid_o & seq_last_o)
                                           : (id_ready_i & active);
            assign busy_o        = ~rst & (step != 5'd0);

            always_ff @(posedge clk) begin
                if (rst || kill_i) begin
                    state <= IDLE;
                    step  <= 5'd0;
                end else if (seq_valid_o && id_ready_i) begin
                    if (uop_last) begin
                        state <= IDLE;
                        step  <= 5'd0;
                    end else begin
                        state <= SEQ;
                        step  <= cur_step + 5'd1;
                    end
                end
            end
        end else begin : g_pass
            assign instr_valid_o = instr_valid_i & ~rst & ~kill_i & ~halt_i;
            assign instr_o       = rst ? 32'h0000_0000 : instr_i;
            assign instr_ready_o = id_ready_i & ~rst & ~kill_i & ~halt_i;
            assign seq_valid_o   = 1'b0;
            assign seq_first_o   = 1'b0;
            assign seq_last_o    = 1'b0;
            assign busy_o        = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_cv32e40s_zcmp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cv32e40s_zcmp_sequencer
// Directed bench: a table of single-cycle vectors {inputs, expected outputs}
// applied in order, plus hand-written popretz (rlist=15) and reset-abort runs.
// Inputs change on the falling edge; outputs are checked 2 time units later.
// ---------------------------------------------------------------------------
module tb_cv32e40s_zcmp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = 32'h0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        id_ready_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        seq_valid_o;
    logic        seq_first_o;
    logic        seq_last_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40s_zcmp_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .id_ready_i    (id_ready_i),
        .kill_i        (kill_i),
        .halt_i        (halt_i),
        .seq_valid_o   (seq_valid_o),
        .seq_first_o   (seq_first_o),
        .seq_last_o    (seq_last_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic        vld;
        logic        rdy;
        logic        kill;
        logic        halt;
        logic [31:0] e_instr;
        logic        e_vld;
        logic        e_rdy;
        logic        e_sv;
        logic        e_first;
        logic        e_last;
        logic        e_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic vld, input logic rdy,
                       input logic kill, input logic halt, input logic [31:0] e_instr,
                       input logic e_vld, input logic e_rdy, input logic e_sv,
                       input logic e_first, input logic e_last, input logic e_busy);
        vec_t v;
        v.instr = instr;     v.vld = vld;     v.rdy = rdy;     v.kill = kill;   v.halt = halt;
        v.e_instr = e_instr; v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_sv = e_sv;
        v.e_first = e_first; v.e_last = e_last; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_instr, input logic e_vld,
                             input logic e_rdy, input logic e_sv, input logic e_first,
                             input logic e_last, input logic e_busy);
        check({tag, " instr_o"}, instr_o, e_instr);
        check({tag, " instr_valid_o"}, {31'b0, instr_valid_o}, {31'b0, e_vld});
        check({tag, " instr_ready_o"}, {31'b0, instr_ready_o}, {31'b0, e_rdy});
        check({tag, " seq_valid_o"}, {31'b0, seq_valid_o}, {31'b0, e_sv});
        check({tag, " seq_first_o"}, {31'b0, seq_first_o}, {31'b0, e_first});
        check({tag, " seq_last_o"}, {31'b0, seq_last_o}, {31'b0, e_last});
        check({tag, " busy_o"}, {31'b0, busy_o}, {31'b0, e_busy});
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        instr_i = v.instr; instr_valid_i = v.vld; id_ready_i = v.rdy;
        kill_i = v.kill;   halt_i = v.halt;
        #2;
        check_all($sformatf("vec%0d", idx), v.e_instr, v.e_vld, v.e_rdy, v.e_sv,
                  v.e_first, v.e_last, v.e_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          regs[13];
        logic [31:0] exp_word;
        regs = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

        // --- vector table (one row per cycle) ---
        // passthrough add, with and without decoder ready
        add(32'h00A50533, 1, 1, 0, 0, 32'h00A50533, 1, 1, 0, 0, 0, 0);
        add(32'h00A50533, 1, 0, 0, 0, 32'h00A50533, 1, 0, 0, 0, 0, 0);
        // push with rlist=3 is not sequenced
        add(32'h0000B836, 1, 1, 0, 0, 32'h0000B836, 1, 1, 0, 0, 0, 0);
        // halted passthrough
        add(32'h00500093, 1, 1, 0, 1, 32'h00500093, 0, 0, 0, 0, 0, 0);
        // cm.mvsa01 s0,s1
`ifdef CV32E40S_ZCMP_MV_EN
        add(32'h0000AC26, 1, 1, 0, 0, 32'h00050413, 1, 0, 1, 1, 0, 0);
        add(32'h0000AC26, 1, 1, 0, 0, 32'h00058493, 1, 1, 1, 0, 1, 1);
`else
        add(32'h0000AC26, 1, 1, 0, 0, 32'h0000AC26, 1, 1, 0, 0, 0, 0);
        add(32'h0000AC26, 1, 1, 0, 0, 32'h0000AC26, 1, 1, 0, 0, 0, 0);
`endif
        // cm.mvsa01 s0,s0 is never sequenced
        add(32'h0000AC22, 1, 1, 0, 0, 32'h0000AC22, 1, 1, 0, 0, 0, 0);
        // cm.push {ra,s0}, spimm=1, with a halt cycle in the middle
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE112E23, 1, 0, 1, 1, 0, 0);
        add(32'h0000B856, 1, 1, 0, 1, 32'hFE812C23, 0, 0, 0, 0, 0, 1);
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE812C23, 1, 0, 1, 0, 0, 1);
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE010113, 1, 1, 1, 0, 1, 1);
        add(32'h00000000, 0, 1, 0, 0, 32'h00000000, 0, 1, 0, 0, 0, 0);
        // same push with id_ready 1,0,0,1,1
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE112E23, 1, 0, 1, 1, 0, 0);
        add(32'h0000B856, 1, 0, 0, 0, 32'hFE812C23, 1, 0, 1, 0, 0, 1);
        add(32'h0000B856, 1, 0, 0, 0, 32'hFE812C23, 1, 0, 1, 0, 0, 1);
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE812C23, 1, 0, 1, 0, 0, 1);
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE010113, 1, 1, 1, 0, 1, 1);
        // cm.popret {ra}, spimm=0
        add(32'h0000BE42, 1, 1, 0, 0, 32'h00C12083, 1, 0, 1, 1, 0, 0);
        add(32'h0000BE42, 1, 1, 0, 0, 32'h01010113, 1, 0, 1, 0, 0, 1);
        add(32'h0000BE42, 1, 1, 0, 0, 32'h00008067, 1, 1, 1, 0, 1, 1);
        // cm.pop {ra,s0,s1} killed at step 2, then addi passes through
        add(32'h0000BA62, 1, 1, 0, 0, 32'h00C12083, 1, 0, 1, 1, 0, 0);
        add(32'h0000BA62, 1, 1, 0, 0, 32'h00812403, 1, 0, 1, 0, 0, 1);
        add(32'h0000BA62, 1, 1, 1, 0, 32'h00412483, 0, 0, 0, 0, 0, 1);
        add(32'h00500093, 1, 1, 0, 0, 32'h00500093, 1, 1, 0, 0, 0, 0);
        // kill wins over halt mid-push
        add(32'h0000B856, 1, 1, 0, 0, 32'hFE112E23, 1, 0, 1, 1, 0, 0);
        add(32'h0000B856, 1, 1, 1, 1, 32'hFE812C23, 0, 0, 0, 0, 0, 1);
        add(32'h00000000, 0, 1, 0, 0, 32'h00000000, 0, 1, 0, 0, 0, 0);

        // --- reset ---
        rst = 1'b1; instr_i = 32'h0000B856; instr_valid_i = 1'b1; id_ready_i = 1'b1;
        #2;
        check_all("reset_t0", 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #2;
        check_all("reset_held", 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; instr_valid_i = 1'b0; instr_i = 32'h0;
        #2;
        check_all("after_reset", 32'h0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

        // --- cm.popretz rlist=15 spimm=3: 16 micro-ops ---
        for (int k = 0; k < 13; k++)
            exp_q.push_back({12'(108 - 4 * k), 5'd2, 3'b010, 5'(regs[k]), 7'b0000011});
        exp_q.push_back(32'h00000513);
        exp_q.push_back(32'h07010113);
        exp_q.push_back(32'h00008067);
        @(negedge clk);
        instr_i = 32'h0000BCFE; instr_valid_i = 1'b1; id_ready_i = 1'b1; kill_i = 1'b0; halt_i = 1'b0;
        for (int n = 0; n < 16; n++) begin
            #2;
            exp_word = exp_q.pop_front();
            check_all($sformatf("popretz%0d", n), exp_word, 1, n == 15, 1, n == 0, n == 15, n != 0);
            @(negedge clk);
        end
        instr_valid_i = 1'b0; instr_i = 32'h0;
        #2;
        check_all("popretz_done", 32'h0, 0, 1, 0, 0, 0, 0);

        // --- reset in the middle of a push aborts it ---
        @(negedge clk);
        instr_i = 32'h0000B856; instr_valid_i = 1'b1; id_ready_i = 1'b1;
        #2;
        check_all("rst_mid_s0", 32'hFE112E23, 1, 0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_all("rst_mid_rst", 32'h0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_all("rst_mid_restart", 32'hFE112E23, 1, 0, 1, 1, 0, 0);
        @(negedge clk);
        instr_valid_i = 1'b0; instr_i = 32'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
